// File: rtl/mult_sched.sv
// Grant/sequencing controller for a shared 8-bit add-shift signed multiplier datapath.
// Define MULT_SCHED_FIXED_PRIO_EN for fixed priority (client 0 wins ties); default is round-robin.
module mult_sched #(
  parameter int N_BITS = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Req,
  input  logic       M,
  output logic [1:0] Gnt,
  output logic       Sel,
  output logic       Clr_XA,
  output logic       Add,
  output logic       Sub,
  output logic       Shift,
  output logic [1:0] Done,
  output logic       Busy
);

  localparam int CW = $clog2(N_BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);
  localparam logic [CW-1:0] SAT  = CW'(N_BITS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_SH   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          sel_q, sel_d;
  logic [1:0]    armed_q, armed_d;
  logic [1:0]    elig;
  logic          winner;
  logic          leaveDone;

`ifdef MULT_SCHED_FIXED_PRIO_EN
  always_comb begin
    elig   = Req & armed_q;
    winner = ~elig[0];
  end
`else
  logic prio_q, prio_d;

  // prio_q names the client that wins when both are eligible
  always_comb begin
    elig   = Req & armed_q;
    winner = (elig == 2'b11) ? prio_q : elig[1];
  end
`endif

  assign leaveDone = (state_q == S_DONE);

  // A held request yields one operation; a low sample re-arms the client
  always_comb begin
    armed_d[0] = ~Req[0] | (armed_q[0] & ~(leaveDone & ~sel_q));
    armed_d[1] = ~Req[1] | (armed_q[1] & ~(leaveDone &  sel_q));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
`ifndef MULT_SCHED_FIXED_PRIO_EN
    prio_d  = prio_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (elig != 2'b00) begin
          state_d = S_LOAD;
          sel_d   = winner;
          gnt_d   = winner ? 2'b10 : 2'b01;
`ifndef MULT_SCHED_FIXED_PRIO_EN
          prio_d  = ~winner;
`endif
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_OP;
      end
      S_OP: begin
        state_d = S_SH;
      end
      S_SH: begin
        if (cnt_q < SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = (cnt_q == LAST) ? S_DONE : S_OP;
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        sel_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        sel_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      sel_q   <= 1'b0;
      armed_q <= 2'b11;
`ifndef MULT_SCHED_FIXED_PRIO_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      armed_q <= armed_d;
`ifndef MULT_SCHED_FIXED_PRIO_EN
      prio_q  <= prio_d;
`endif
    end
  end

  // The last set multiplier bit carries negative weight, hence Sub instead of Add
  always_comb begin
    Gnt    = gnt_q;
    Sel    = sel_q;
    Clr_XA = (state_q == S_LOAD);
    Add    = (state_q == S_OP) && M && (cnt_q < LAST);
    Sub    = (state_q == S_OP) && M && (cnt_q == LAST);
    Shift  = (state_q == S_SH);
    Done   = (state_q == S_DONE) ? {sel_q, ~sel_q} : 2'b00;
    Busy   = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: operation-level reference model, datapath model driving M,
// table-driven single operations, contention, mid-op request drop, async reset and random traffic.
module tb_mult_sched;

  localparam int N     = 8;
  localparam int OPLEN = 2 * N + 2;

  logic       Clk;
  logic       Reset;
  logic [1:0] Req;
  logic       M;
  logic [1:0] Gnt;
  logic       Sel;
  logic       Clr_XA;
  logic       Add;
  logic       Sub;
  logic       Shift;
  logic [1:0] Done;
  logic       Busy;

  int tests = 0;
  int fails = 0;

  mult_sched #(.N_BITS(N)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .M(M),
    .Gnt(Gnt), .Sel(Sel), .Clr_XA(Clr_XA), .Add(Add), .Sub(Sub),
    .Shift(Shift), .Done(Done), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Datapath stand-in: X/A/B registers driven by the DUT strobes
  logic       dpX;
  logic [7:0] dpA, dpB, dpS;
  logic [7:0] opB [2];
  logic [7:0] opS [2];
  assign M = dpB[0];

  // Reference model: one operation is OPLEN cycles, phase mK counts 1..OPLEN
  logic       mOp;
  int         mK;
  logic       mOwner;
  logic [1:0] mArmed;
  logic       mPrio;
  logic [7:0] mB;

  logic [1:0] prevGnt, lastDone, doneVal, lastGntVal;
  int         gntAge, doneAge, gntRiseCnt, nAdd, nSub, nShift, nClr;
  logic       doneSeen;
  logic [1:0] grantQ[$];

  typedef struct {
    int         client;
    logic [7:0] b;
    logic [7:0] s;
    logic [15:0] prod;
    int         adds;
    int         subs;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] expectedOut();
    logic [1:0] g, d;
    logic sl, clr, ad, sb, sh, bz;
    int j, i;
    g = 2'b00; d = 2'b00; sl = 1'b0; clr = 1'b0; ad = 1'b0; sb = 1'b0; sh = 1'b0; bz = 1'b0;
    if (mOp) begin
      g  = mOwner ? 2'b10 : 2'b01;
      sl = mOwner;
      bz = 1'b1;
      if (mK == 1) clr = 1'b1;
      else if (mK == OPLEN) d = g;
      else begin
        j = mK - 2;
        i = j / 2;
        if (j % 2 == 0) begin
          ad = mB[i] && (i < N - 1);
          sb = mB[i] && (i == N - 1);
        end else begin
          sh = 1'b1;
        end
      end
    end
    return {g, sl, clr, ad, sb, sh, d, bz};
  endfunction

  task automatic modelReset();
    mOp = 1'b0; mK = 0; mOwner = 1'b0; mArmed = 2'b11; mPrio = 1'b0; mB = 8'h00;
  endtask

  task automatic modelEdge(input logic [1:0] r);
    logic [1:0] elig, nextArmed;
    logic w;
    elig = r & mArmed;
    for (int i = 0; i < 2; i++)
      nextArmed[i] = !r[i] ? 1'b1 : ((mOp && mK == OPLEN && int'(mOwner) == i) ? 1'b0 : mArmed[i]);
    if (mOp) begin
      if (mK == OPLEN) mOp = 1'b0;
      else mK++;
    end else if (elig != 2'b00) begin
`ifdef MULT_SCHED_FIXED_PRIO_EN
      w = elig[0] ? 1'b0 : 1'b1;
`else
      w = (elig == 2'b11) ? mPrio : elig[1];
      mPrio = !w;
`endif
      mOp = 1'b1; mK = 1; mOwner = w; mB = opB[w];
    end
    mArmed = nextArmed;
  endtask

  task automatic clearObs();
    prevGnt = 2'b00; lastDone = 2'b00; doneVal = 2'b00; lastGntVal = 2'b00;
    gntAge = 0; doneAge = 0; gntRiseCnt = 0; doneSeen = 1'b0;
    nAdd = 0; nSub = 0; nShift = 0; nClr = 0;
    grantQ.delete();
  endtask

  task automatic checkOutput();
    logic [9:0] act;
    check("strobe_onehot0", ($countones({Clr_XA, Add, Sub, Shift}) <= 1), 1);
    check("gnt_onehot0", $onehot0(Gnt), 1);
    check("done_in_gnt", ((Done & ~Gnt) == 2'b00), 1);
    act = {Gnt, (Gnt != 2'b00) ? Sel : 1'b0, Clr_XA, Add, Sub, Shift, Done, Busy};
    check("cycle_outputs", act, expectedOut());
    if (Gnt != 2'b00) begin
      if (prevGnt == 2'b00) begin
        gntRiseCnt++; lastGntVal = Gnt; gntAge = 1; grantQ.push_back(Gnt);
      end else gntAge++;
    end else gntAge = 0;
    if (Done != 2'b00) begin
      doneSeen = 1'b1; doneVal = Done; doneAge = gntAge;
    end
    nAdd += int'(Add); nSub += int'(Sub); nShift += int'(Shift); nClr += int'(Clr_XA);
    lastDone = Done;
    prevGnt = Gnt;
  endtask

  task automatic applyDatapath();
    if (Clr_XA) begin
      dpX = 1'b0; dpA = 8'h00; dpB = opB[Sel]; dpS = opS[Sel];
    end else if (Add) {dpX, dpA} = {dpA[7], dpA} + {dpS[7], dpS};
    else if (Sub) {dpX, dpA} = {dpA[7], dpA} - {dpS[7], dpS};
    else if (Shift) {dpX, dpA, dpB} = {dpX, dpX, dpA, dpB[7:1]};
  endtask

  task automatic applyStimulus(input logic [1:0] r);
    @(negedge Clk);
    checkOutput();
    applyDatapath();
    Req = r;
    @(posedge Clk);
    modelEdge(r);
  endtask

  task automatic doReset();
    @(negedge Clk);
    Req = 2'b00;
    Reset = 1'b0;
    modelReset();
    @(posedge Clk);
    @(negedge Clk);
    #1 Reset = 1'b1;
    clearObs();
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [1:0] oneHot, rq;
    logic [1:0] expSeq [4];
    vecs[0] = '{0, 8'h07, 8'h03, 16'h0015, 3, 0};
    vecs[1] = '{0, 8'h80, 8'h02, 16'hFF00, 0, 1};
    vecs[2] = '{1, 8'hFF, 8'h05, 16'hFFFB, 7, 1};
    vecs[3] = '{1, 8'h81, 8'hFD, 16'h017D, 1, 1};
    vecs[4] = '{0, 8'h00, 8'h7F, 16'h0000, 0, 0};
    vecs[5] = '{1, 8'h7F, 8'h80, 16'hC080, 7, 0};
    vecs[6] = '{0, 8'h55, 8'hAA, 16'hE372, 4, 0};
    expSeq  = '{2'b01, 2'b10, 2'b01, 2'b10};

    Reset = 1'b0; Req = 2'b00;
    dpX = 1'b0; dpA = 8'h00; dpB = 8'h00; dpS = 8'h00;
    opB[0] = 8'h00; opB[1] = 8'h00; opS[0] = 8'h00; opS[1] = 8'h00;
    modelReset();
    clearObs();
    @(negedge Clk);
    #1 check("reset_outputs", {Gnt, Sel, Clr_XA, Add, Sub, Shift, Done, Busy}, 0);
    doReset();

    $display("[TB] table-driven single operations");
    foreach (vecs[v]) begin
      oneHot = (vecs[v].client == 1) ? 2'b10 : 2'b01;
      opB[vecs[v].client] = vecs[v].b;
      opS[vecs[v].client] = vecs[v].s;
      clearObs();
      for (int n = 0; n < 40 && !doneSeen; n++) applyStimulus(oneHot);
      check("done_seen", doneSeen, 1);
      check("grant", lastGntVal, oneHot);
      check("done_value", doneVal, oneHot);
      check("done_latency", doneAge, OPLEN);
      check("add_count", nAdd, vecs[v].adds);
      check("sub_count", nSub, vecs[v].subs);
      check("shift_count", nShift, N);
      check("clr_count", nClr, 1);
      check("product", {dpA, dpB}, vecs[v].prod);
      repeat (4) applyStimulus(oneHot);
      check("no_rerun_held_req", gntRiseCnt, 1);
      applyStimulus(2'b00);
    end

    $display("[TB] contention with both requests held");
    doReset();
    opB[0] = 8'h13; opS[0] = 8'h21; opB[1] = 8'hC4; opS[1] = 8'h09;
    for (int n = 0; n < 200 && grantQ.size() < 5; n++) applyStimulus(2'b11 & ~lastDone);
    check("contention_grants", grantQ.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grantQ.size(); i++) check("contention_order", grantQ[i], expSeq[i]);

    $display("[TB] request drop mid-operation");
    doReset();
    opB[1] = 8'h5A; opS[1] = 8'h13;
    for (int n = 0; n < 40 && !doneSeen; n++) applyStimulus((gntAge >= 8) ? 2'b00 : 2'b10);
    check("drop_done_seen", doneSeen, 1);
    check("drop_done_value", doneVal, 2'b10);
    check("drop_product", {dpA, dpB}, 16'h06AE);
    applyStimulus(2'b00);
    gntRiseCnt = 0;
    applyStimulus(2'b10);
    applyStimulus(2'b10);
    check("drop_regrant_count", gntRiseCnt, 1);
    check("drop_regrant", lastGntVal, 2'b10);

    $display("[TB] asynchronous reset mid-operation");
    doReset();
    opB[0] = 8'hFF; opS[0] = 8'h11;
    for (int n = 0; n < 40 && gntAge < 12; n++) applyStimulus(2'b01);
    check("reach_iter5", gntAge, 12);
    #2 Reset = 1'b0;
    Req = 2'b00;
    #1 check("async_reset_outputs", {Gnt, Busy, Clr_XA, Add, Sub, Shift, Done}, 0);
    modelReset();
    @(posedge Clk);
    @(negedge Clk);
    #1 Reset = 1'b1;
    clearObs();
    applyStimulus(2'b10);
    applyStimulus(2'b10);
    check("post_reset_grant_count", gntRiseCnt, 1);
    check("post_reset_grant", lastGntVal, 2'b10);
    check("post_reset_no_done", doneSeen, 0);

    $display("[TB] random traffic against reference model");
    doReset();
    rq = 2'b00;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 5) == 0) rq[c] = ~rq[c];
        if (!rq[c] && !mOp) begin
          opB[c] = 8'($urandom);
          opS[c] = 8'($urandom);
        end
      end
      applyStimulus(rq);
    end
    check("random_activity", gntRiseCnt > 10, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
